// File: rtl/gray_ptr_counter.sv
// Binary up/down counter with a registered Gray-code image of the count.
// Optional macro GRAY_STEP_CHECK_EN adds a sticky step_err flag for non-unit Gray steps.
module gray_ptr_counter #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    input  logic             dec,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] bin,
    output logic [WIDTH-1:0] gray,
    output logic             wrap
`ifdef GRAY_STEP_CHECK_EN
    ,
    output logic             step_err
`endif
);

    localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

    function automatic logic [WIDTH-1:0] to_gray(input logic [WIDTH-1:0] x);
        return x ^ (x >> 1);
    endfunction

    logic             step_up;
    logic             step_dn;
    logic [WIDTH-1:0] next_bin;
    logic             next_wrap;

    assign step_up = inc & ~dec;
    assign step_dn = dec & ~inc;

    always_comb begin
        next_bin  = bin;
        next_wrap = 1'b0;
        if (load) begin
            next_bin = load_val;
        end else if (step_up) begin
            next_bin  = bin + ONE;
            next_wrap = (bin == '1);
        end else if (step_dn) begin
            next_bin  = bin - ONE;
            next_wrap = (bin == '0);
        end
    end

    // Gray is registered from next_bin so both outputs change on the same edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            bin  <= '0;
            gray <= '0;
            wrap <= 1'b0;
        end else begin
            bin  <= next_bin;
            gray <= to_gray(next_bin);
            wrap <= next_wrap;
        end
    end

`ifdef GRAY_STEP_CHECK_EN
    function automatic logic is_one_hot(input logic [WIDTH-1:0] x);
        return (x != '0) && ((x & (x - ONE)) == '0);
    endfunction

    logic [WIDTH-1:0] gray_prev_p1;
    logic             step_p1;

    always_ff @(posedge clk) begin
        gray_prev_p1 <= gray;
    end

    // step_p1 marks that the current gray came from a step; compare against the prior code.
    always_ff @(posedge clk) begin
        if (rst) begin
            step_p1  <= 1'b0;
            step_err <= 1'b0;
        end else begin
            step_p1 <= ~load & (step_up | step_dn);
            if (step_p1 && !is_one_hot(gray ^ gray_prev_p1)) begin
                step_err <= 1'b1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_gray_ptr_counter.sv
// Randomized and directed bench for gray_ptr_counter against an arithmetic reference model.
module tb_gray_ptr_counter;

    localparam int WIDTH = 8;
    localparam int MOD   = 1 << WIDTH;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             inc = 1'b0;
    logic             dec = 1'b0;
    logic             load = 1'b0;
    logic [WIDTH-1:0] load_val = '0;
    logic [WIDTH-1:0] bin;
    logic [WIDTH-1:0] gray;
    logic             wrap;
`ifdef GRAY_STEP_CHECK_EN
    logic             step_err;
`endif

    int checks = 0;
    int errors = 0;

    gray_ptr_counter #(.WIDTH(WIDTH)) dut (
        .clk      (clk),
        .rst      (rst),
        .inc      (inc),
        .dec      (dec),
        .load     (load),
        .load_val (load_val),
        .bin      (bin),
        .gray     (gray),
        .wrap     (wrap)
`ifdef GRAY_STEP_CHECK_EN
        ,
        .step_err (step_err)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: plain modular arithmetic on an integer count.
    int mb = 0;
    int mw = 0;
    bit mstep = 0;
    bit mvalid = 0;

    always @(posedge clk) begin
        mstep <= 1'b0;
        if (rst) begin
            mb <= 0; mw <= 0; mvalid <= 1'b1;
        end else if (load) begin
            mb <= int'(load_val); mw <= 0;
        end else if (inc && !dec) begin
            mw <= (mb == MOD - 1) ? 1 : 0; mb <= (mb + 1) % MOD; mstep <= 1'b1;
        end else if (dec && !inc) begin
            mw <= (mb == 0) ? 1 : 0; mb <= (mb + MOD - 1) % MOD; mstep <= 1'b1;
        end else begin
            mw <= 0;
        end
    end

    logic [WIDTH-1:0] prev_gray = '0;
    bit               prev_ok = 0;

    always @(negedge clk) begin
        if (mvalid) begin
            chk("model_bin", int'(bin), mb);
            chk("model_gray", int'(gray), mb ^ (mb >> 1));
            chk("model_wrap", int'(wrap), mw);
            if (mstep && prev_ok) chk("gray_one_bit_step", $countones(gray ^ prev_gray), 1);
`ifdef GRAY_STEP_CHECK_EN
            chk("step_err_low", int'(step_err), 0);
`endif
            prev_gray = gray;
            prev_ok   = 1'b1;
        end
    end

    task automatic cyc(input logic r, input logic i, input logic d, input logic l, input int v);
        rst = r; inc = i; dec = d; load = l; load_val = WIDTH'(v);
        @(negedge clk);
    endtask

    int gray_tab[5] = '{1, 3, 2, 6, 7};
    int wraps;

    initial begin
        // 1: reset then five increments
        cyc(1, 0, 0, 0, 0);
        chk("reset_bin", int'(bin), 0);
        chk("reset_gray", int'(gray), 0);
        chk("reset_wrap", int'(wrap), 0);
        for (int k = 0; k < 5; k++) begin
            cyc(0, 1, 0, 0, 0);
            chk("inc_bin", int'(bin), k + 1);
            chk("inc_gray", int'(gray), gray_tab[k]);
            chk("inc_wrap", int'(wrap), 0);
        end

        // 2: load 170 then idle
        cyc(0, 0, 0, 1, 170);
        chk("load170_bin", int'(bin), 170);
        chk("load170_gray", int'(gray), 255);
        cyc(0, 0, 0, 0, 0);
        chk("idle_bin", int'(bin), 170);
        chk("idle_gray", int'(gray), 255);
        chk("idle_wrap", int'(wrap), 0);

        // 3: load 255 then inc wraps
        cyc(0, 1, 1, 1, 255);
        chk("load255_gray", int'(gray), 128);
        chk("load255_wrap", int'(wrap), 0);
        cyc(0, 1, 0, 0, 0);
        chk("wrapup_bin", int'(bin), 0);
        chk("wrapup_gray", int'(gray), 0);
        chk("wrapup_wrap", int'(wrap), 1);
        cyc(0, 0, 0, 0, 0);
        chk("wrapup_pulse_end", int'(wrap), 0);

        // 4: dec from 0, then inc=dec=1 twice
        cyc(0, 0, 1, 0, 0);
        chk("wrapdn_bin", int'(bin), 255);
        chk("wrapdn_gray", int'(gray), 128);
        chk("wrapdn_wrap", int'(wrap), 1);
        for (int k = 0; k < 2; k++) begin
            cyc(0, 1, 1, 0, 0);
            chk("both_bin", int'(bin), 255);
            chk("both_wrap", int'(wrap), 0);
        end

        // 5: count to 100 then reset with load
        cyc(1, 0, 0, 0, 0);
        for (int k = 0; k < 100; k++) cyc(0, 1, 0, 0, 0);
        chk("count100_bin", int'(bin), 100);
        cyc(1, 0, 0, 1, 42);
        chk("rstload_bin", int'(bin), 0);
        chk("rstload_gray", int'(gray), 0);
        chk("rstload_wrap", int'(wrap), 0);
        cyc(0, 1, 0, 0, 0);
        chk("after_rst_bin", int'(bin), 1);

        // 6: long runs from zero
        cyc(1, 0, 0, 0, 0);
        wraps = 0;
        for (int k = 0; k < 600; k++) begin
            cyc(0, 1, 0, 0, 0);
            wraps += int'(wrap);
        end
        chk("inc_run_wraps", wraps, 2);
        wraps = 0;
        for (int k = 0; k < 300; k++) begin
            cyc(0, 0, 1, 0, 0);
            wraps += int'(wrap);
        end
        chk("dec_run_wraps", wraps, 1);

        // Random mix, checked cycle by cycle against the model
        for (int k = 0; k < 2000; k++) begin
            automatic int sel = int'($urandom_range(0, 99));
            cyc(sel < 2, sel >= 2 && sel < 50 || sel >= 90, sel >= 45 && sel < 90 || sel >= 95,
                sel >= 80 && sel < 88, int'($urandom_range(0, MOD - 1)));
        end
        cyc(0, 0, 0, 0, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
